rubik_move_sequencer: RTL and testbench

Converts one cube move (face, turn) into an ordered series of primitive servo commands for the servo manager: optional whole-cube base pre-rotation, 0-2 peteleco flips, lid down, base layer turn, lid up. It sits between the solution-playback control (upstream) and the servo manager (downstream). It issues one-cycle move strobes and waits for the manager's one-cycle pronto before each next step.

---
 rtl/rubik_move_sequencer_pkg.sv | 73 +++++++
 rtl/rubik_move_sequencer_if.sv | 29 ++
 rtl/rubik_move_sequencer_step_watchdog.sv | 28 ++
 rtl/rubik_move_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_rubik_move_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rubik_move_sequencer_pkg.sv
// Shared encodings and the per-face plan table for the cube move sequencer.
package rubik_move_sequencer_pkg;

  typedef enum logic [2:0] {
    FaceU = 3'd0,
    FaceD = 3'd1,
    FaceF = 3'd2,
    FaceB = 3'd3,
    FaceL = 3'd4,
    FaceR = 3'd5
  } face_e;

  typedef enum logic [1:0] {
    TurnCw  = 2'd0,
    TurnCcw = 2'd1,
    Turn180 = 2'd2
  } turn_e;

  typedef enum logic [1:0] {
    BaseNone = 2'd0,
    BaseCw   = 2'd1,
    BaseCcw  = 2'd2,
    Base180  = 2'd3
  } base_dir_e;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StLoad     = 4'd1,
    StPreReq   = 4'd2,
    StPreWait  = 4'd3,
    StFlipReq  = 4'd4,
    StFlipWait = 4'd5,
    StLdnReq   = 4'd6,
    StLdnWait  = 4'd7,
    StTurnReq  = 4'd8,
    StTurnWait = 4'd9,
    StLupReq   = 4'd10,
    StLupWait  = 4'd11,
    StDone     = 4'd12,
    StErro     = 4'd13
  } state_e;

  typedef struct packed {
    base_dir_e  pre;
    logic [1:0] flips;
  } plan_t;

  // Whole-cube pre-rotation and flip count that bring the target face to the bottom.
  function automatic plan_t plan_of(logic [2:0] face);
    case (face)
      FaceD:   plan_of = '{pre: BaseNone, flips: 2'd0};
      FaceU:   plan_of = '{pre: BaseNone, flips: 2'd2};
      FaceB:   plan_of = '{pre: BaseNone, flips: 2'd1};
      FaceF:   plan_of = '{pre: Base180,  flips: 2'd1};
      FaceL:   plan_of = '{pre: BaseCw,   flips: 2'd1};
      FaceR:   plan_of = '{pre: BaseCcw,  flips: 2'd1};
      default: plan_of = '{pre: BaseNone, flips: 2'd0};
    endcase
  endfunction

  function automatic base_dir_e dir_of_turn(logic [1:0] turn);
    case (turn)
      TurnCw:  dir_of_turn = BaseCw;
      TurnCcw: dir_of_turn = BaseCcw;
      default: dir_of_turn = Base180;
    endcase
  endfunction

  function automatic logic is_valid(logic [2:0] face, logic [1:0] turn);
    is_valid = (face <= 3'd5) && (turn <= 2'd2);
  endfunction

endpackage

// File: rtl/rubik_move_sequencer_if.sv
// Handshake bundle between playback control, the move sequencer and the servo manager.
interface rubik_move_sequencer_if;
  logic       iniciar;
  logic [2:0] face;
  logic [1:0] turn;
  logic       servo_pronto;
  logic       move_servo_peteleco;
  logic       move_servo_tampa;
  logic       move_servo_base;
  logic       tampa_baixa;
  logic [1:0] base_dir;
  logic       ocupado;
  logic       pronto;
  logic       invalido;
  logic       erro;
  logic [3:0] db_estado;

  modport slave (
    input  iniciar, face, turn, servo_pronto,
    output move_servo_peteleco, move_servo_tampa, move_servo_base, tampa_baixa, base_dir,
           ocupado, pronto, invalido, erro, db_estado
  );

  modport master (
    output iniciar, face, turn, servo_pronto,
    input  move_servo_peteleco, move_servo_tampa, move_servo_base, tampa_baixa, base_dir,
           ocupado, pronto, invalido, erro, db_estado
  );
endinterface

// File: rtl/rubik_move_sequencer_step_watchdog.sv
// Per-step watchdog: counts while run is high, clears when it drops, flags the last allowed cycle.
module rubik_step_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned TMR_W          = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam logic [TMR_W-1:0] Last = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (!run) begin
      count_q <= '0;
    end else if (count_q != Last) begin
      count_q <= count_q + TMR_W'(1);
    end
  end

  assign expired = run && (count_q == Last);

endmodule

// File: rtl/rubik_move_sequencer.sv
// Expands one cube move into pre-rotation, flips, lid down, base turn and lid up servo steps.
// Optional per-step watchdog enabled by defining WATCHDOG_EN.
module rubik_move_sequencer
  import rubik_move_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned TMR_W          = 26
) (
  input logic                   clock,
  input logic                   reset,
  rubik_move_sequencer_if.slave bus
);

  if ((64'd1 << TMR_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("TMR_W too narrow for TIMEOUT_CYCLES");
  end

  state_e     state_q, state_d;
  logic [2:0] face_r, face_d;
  logic [1:0] turn_r, turn_d;
  logic [1:0] flips_r, flips_d;
  base_dir_e  pre_r, pre_d;
  logic       invalido_q, invalido_d;

  plan_t      plan;
  logic       wd_expired;

  logic       move_peteleco, move_tampa, move_base, tampa_baixa, pronto;
  base_dir_e  base_dir;

  assign plan = plan_of(face_r);

`ifdef WATCHDOG_EN
  logic in_wait;

  assign in_wait = state_q inside {StPreWait, StFlipWait, StLdnWait, StTurnWait, StLupWait};

  rubik_step_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .run    (in_wait),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      face_r     <= '0;
      turn_r     <= '0;
      flips_r    <= '0;
      pre_r      <= BaseNone;
      invalido_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      face_r     <= face_d;
      turn_r     <= turn_d;
      flips_r    <= flips_d;
      pre_r      <= pre_d;
      invalido_q <= invalido_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    face_d        = face_r;
    turn_d        = turn_r;
    flips_d       = flips_r;
    pre_d         = pre_r;
    invalido_d    = 1'b0;
    move_peteleco = 1'b0;
    move_tampa    = 1'b0;
    move_base     = 1'b0;
    tampa_baixa   = 1'b0;
    base_dir      = BaseNone;
    pronto        = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.iniciar) begin
          if (is_valid(bus.face, bus.turn)) begin
            face_d  = bus.face;
            turn_d  = bus.turn;
            state_d = StLoad;
          end else begin
            invalido_d = 1'b1;
          end
        end
      end
      StLoad: begin
        pre_d   = plan.pre;
        flips_d = plan.flips;
        if (plan.pre != BaseNone)    state_d = StPreReq;
        else if (plan.flips != 2'd0) state_d = StFlipReq;
        else                         state_d = StLdnReq;
      end
      StPreReq: begin
        move_base = 1'b1;
        base_dir  = pre_r;
        state_d   = StPreWait;
      end
      StPreWait: begin
        base_dir = pre_r;
        if (bus.servo_pronto) state_d = (flips_r != 2'd0) ? StFlipReq : StLdnReq;
        else if (wd_expired)  state_d = StErro;
      end
      StFlipReq: begin
        move_peteleco = 1'b1;
        state_d       = StFlipWait;
      end
      StFlipWait: begin
        if (bus.servo_pronto) begin
          flips_d = flips_r - 2'd1;
          state_d = (flips_r != 2'd1) ? StFlipReq : StLdnReq;
        end else if (wd_expired) begin
          state_d = StErro;
        end
      end
      StLdnReq: begin
        move_tampa  = 1'b1;
        tampa_baixa = 1'b1;
        state_d     = StLdnWait;
      end
      StLdnWait: begin
        tampa_baixa = 1'b1;
        if (bus.servo_pronto) state_d = StTurnReq;
        else if (wd_expired)  state_d = StErro;
      end
      StTurnReq: begin
        move_base = 1'b1;
        base_dir  = dir_of_turn(turn_r);
        state_d   = StTurnWait;
      end
      StTurnWait: begin
        base_dir = dir_of_turn(turn_r);
        if (bus.servo_pronto) state_d = StLupReq;
        else if (wd_expired)  state_d = StErro;
      end
      StLupReq: begin
        move_tampa = 1'b1;
        state_d    = StLupWait;
      end
      StLupWait: begin
        if (bus.servo_pronto) state_d = StDone;
        else if (wd_expired)  state_d = StErro;
      end
      StDone: begin
        pronto  = 1'b1;
        state_d = StIdle;
      end
      StErro: begin
        state_d = StErro;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.move_servo_peteleco = move_peteleco;
  assign bus.move_servo_tampa    = move_tampa;
  assign bus.move_servo_base     = move_base;
  assign bus.tampa_baixa         = tampa_baixa;
  assign bus.base_dir            = base_dir;
  assign bus.ocupado             = (state_q >= StLoad) && (state_q <= StLupWait);
  assign bus.pronto              = pronto;
  assign bus.invalido            = invalido_q;
  assign bus.db_estado           = state_q;

`ifdef WATCHDOG_EN
  assign bus.erro = (state_q == StErro);
`else
  assign bus.erro = 1'b0;
`endif

endmodule

// File: tb/tb_rubik_move_sequencer.sv
// Directed table-driven bench for rubik_move_sequencer with a servo manager stub (5-cycle replies).
module tb_rubik_move_sequencer;

  typedef struct packed {
    logic [2:0]      face;
    logic [1:0]      turn;
    logic [3:0]      n;      // 0 marks an invalid request
    logic [4:0][7:0] steps;  // 8'h1d base dir d, 8'h20 flip, 8'h3b lid baixa b
    logic [7:0]      lat;    // negedges from iniciar cycle to pronto
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rubik_move_sequencer_if bus ();

  logic stub_pronto  = 1'b0;
  logic extra_pronto = 1'b0;
  logic skip_flip    = 1'b0;
  assign bus.servo_pronto = stub_pronto | extra_pronto;

  rubik_move_sequencer #(
    .TIMEOUT_CYCLES(20),
    .TMR_W         (26)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] log_q[$];
  int         multi_err = 0;
  int         hold_err = 0;
  int         erro_seen = 0;
  int         stub_cnt = 0;
  logic [1:0] last_dir = 2'd0;
  vec_t       vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] f, input logic [1:0] t, input logic [3:0] n,
                              input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input logic [7:0] s4, input logic [7:0] lat);
    vec_t v;
    v.face     = f;
    v.turn     = t;
    v.n        = n;
    v.steps[0] = s0;
    v.steps[1] = s1;
    v.steps[2] = s2;
    v.steps[3] = s3;
    v.steps[4] = s4;
    v.lat      = lat;
    return v;
  endfunction

  function automatic logic [19:0] all_outs();
    return {bus.move_servo_peteleco, bus.move_servo_tampa, bus.move_servo_base, bus.tampa_baixa,
            bus.base_dir, bus.ocupado, bus.pronto, bus.invalido, bus.erro, bus.db_estado, 6'd0};
  endfunction

  // Servo stub, strobe log and Moore-hold monitor.
  always @(negedge clock) begin
    int ns;
    stub_pronto = 1'b0;
    if (reset) begin
      stub_cnt = 0;
    end else begin
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) stub_pronto = 1'b1;
      end
      ns = int'(bus.move_servo_peteleco) + int'(bus.move_servo_tampa) + int'(bus.move_servo_base);
      if (ns > 1) multi_err++;
      if (bus.move_servo_peteleco) begin
        log_q.push_back(8'h20);
        if (!skip_flip) stub_cnt = 5;
      end
      if (bus.move_servo_base) begin
        log_q.push_back(8'h10 | {6'd0, bus.base_dir});
        last_dir = bus.base_dir;
        stub_cnt = 5;
      end
      if (bus.move_servo_tampa) begin
        log_q.push_back(8'h30 | {7'd0, bus.tampa_baixa});
        stub_cnt = 5;
      end
      case (bus.db_estado)
        4'd3, 4'd9: if (bus.base_dir !== last_dir) hold_err++;
        4'd2, 4'd8: ;
        default:    if (bus.base_dir !== 2'd0) hold_err++;
      endcase
      if (((bus.db_estado == 4'd6) || (bus.db_estado == 4'd7)) !== bus.tampa_baixa) hold_err++;
      if (bus.erro) erro_seen++;
    end
  end

  // Runs one move; optionally injects a second iniciar at negedge inject_at while busy.
  task automatic run_move(input logic [2:0] f, input logic [1:0] t, input int inject_at,
                          output int lat, output int ocu_low);
    lat     = 0;
    ocu_low = 0;
    log_q.delete();
    hold_err  = 0;
    multi_err = 0;
    @(negedge clock);
    bus.face    = f;
    bus.turn    = t;
    bus.iniciar = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      bus.iniciar = 1'b0;
      if (inject_at != 0 && k == inject_at) begin
        bus.face    = 3'd2;
        bus.turn    = 2'd2;
        bus.iniciar = 1'b1;
      end
      if (bus.pronto) begin
        lat = k;
        break;
      end
      if (!bus.ocupado) ocu_low++;
    end
    bus.iniciar = 1'b0;
  endtask

  task automatic check_log(input string tag, input vec_t v);
    chk({tag, "_strobe_count"}, 32'(log_q.size()), 32'(v.n));
    for (int j = 0; j < int'(v.n); j++) begin
      chk($sformatf("%s_strobe%0d", tag, j), 32'((j < log_q.size()) ? log_q[j] : 8'hFF),
          32'(v.steps[j]));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, ocu_low, found;
    bus.iniciar = 1'b0;
    bus.face    = 3'd0;
    bus.turn    = 2'd0;

    repeat (2) @(negedge clock);
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    reset = 1'b0;

    vecs[0] = mk(3'd1, 2'd0, 4'd3, 8'h31, 8'h11, 8'h30, 8'h00, 8'h00, 8'd20);  // D CW
    vecs[1] = mk(3'd2, 2'd2, 4'd5, 8'h13, 8'h20, 8'h31, 8'h13, 8'h30, 8'd32);  // F 180
    vecs[2] = mk(3'd0, 2'd1, 4'd5, 8'h20, 8'h20, 8'h31, 8'h12, 8'h30, 8'd32);  // U CCW
    vecs[3] = mk(3'd3, 2'd0, 4'd4, 8'h20, 8'h31, 8'h11, 8'h30, 8'h00, 8'd26);  // B CW
    vecs[4] = mk(3'd4, 2'd2, 4'd5, 8'h11, 8'h20, 8'h31, 8'h13, 8'h30, 8'd32);  // L 180
    vecs[5] = mk(3'd5, 2'd0, 4'd5, 8'h12, 8'h20, 8'h31, 8'h11, 8'h30, 8'd32);  // R CW
    vecs[6] = mk(3'd6, 2'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0);   // bad face
    vecs[7] = mk(3'd2, 2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0);   // bad turn
    vecs[8] = mk(3'd7, 2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0);   // both bad

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].n == 4'd0) begin
        log_q.delete();
        @(negedge clock);
        bus.face    = vecs[i].face;
        bus.turn    = vecs[i].turn;
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
        chk($sformatf("v%0d_invalido_pulse", i), 32'(bus.invalido), 32'd1);
        chk($sformatf("v%0d_state_idle", i), 32'(bus.db_estado), 32'd0);
        @(negedge clock);
        chk($sformatf("v%0d_invalido_end", i), 32'(bus.invalido), 32'd0);
        repeat (3) @(negedge clock);
        chk($sformatf("v%0d_no_strobes", i), 32'(log_q.size()), 32'd0);
      end else begin
        run_move(vecs[i].face, vecs[i].turn, 0, lat, ocu_low);
        chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        check_log($sformatf("v%0d", i), vecs[i]);
        chk($sformatf("v%0d_ocupado", i), 32'(ocu_low), 32'd0);
        chk($sformatf("v%0d_dir_hold", i), 32'(hold_err), 32'd0);
        chk($sformatf("v%0d_one_strobe", i), 32'(multi_err), 32'd0);
        @(negedge clock);
        chk($sformatf("v%0d_pronto_once", i), {30'd0, bus.pronto, bus.ocupado}, 32'd0);
        chk($sformatf("v%0d_back_idle", i), 32'(bus.db_estado), 32'd0);
      end
    end

    // iniciar while busy is dropped; the D move completes unchanged
    run_move(3'd1, 2'd0, 3, lat, ocu_low);
    chk("busy_latency", 32'(lat), 32'd20);
    check_log("busy", vecs[0]);
    @(negedge clock);
    repeat (3) @(negedge clock);
    chk("busy_no_requeue", 32'(bus.db_estado), 32'd0);

    // stray servo_pronto in IDLE is ignored
    log_q.delete();
    @(negedge clock);
    extra_pronto = 1'b1;
    @(negedge clock);
    extra_pronto = 1'b0;
    repeat (2) @(negedge clock);
    chk("stray_pronto_idle", {28'd0, bus.db_estado}, 32'd0);
    chk("stray_pronto_strobes", 32'(log_q.size()), 32'd0);

    // asynchronous reset in TURN_WAIT
    @(negedge clock);
    bus.face    = 3'd1;
    bus.turn    = 2'd0;
    bus.iniciar = 1'b1;
    found       = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      bus.iniciar = 1'b0;
      if (bus.db_estado == 4'd9) begin
        found = 1;
        break;
      end
    end
    chk("reach_turn_wait", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", 32'(all_outs()), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_move(3'd1, 2'd0, 0, lat, ocu_low);
    chk("after_reset_latency", 32'(lat), 32'd20);
    check_log("after_reset", vecs[0]);

`ifdef WATCHDOG_EN
    // stub never answers the flip: erro in cycle 20 counted from FLIP_WAIT entry
    skip_flip = 1'b1;
    @(negedge clock);
    bus.face    = 3'd3;
    bus.turn    = 2'd0;
    bus.iniciar = 1'b1;
    found       = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      bus.iniciar = 1'b0;
      if (bus.db_estado == 4'd5) begin
        found = 1;
        break;
      end
    end
    chk("wd_reach_flip_wait", 32'(found), 32'd1);
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (bus.erro) begin
        found = k;
        break;
      end
    end
    chk("wd_erro_cycle", 32'(found), 32'd20);
    chk("wd_erro_state", 32'(bus.db_estado), 32'd13);
    log_q.delete();
    repeat (30) @(negedge clock);
    chk("wd_no_strobes", 32'(log_q.size()), 32'd0);
    chk("wd_erro_sticky", {28'd0, bus.erro, 3'd0}, 32'h8);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset     = 1'b0;
    skip_flip = 1'b0;
    chk("wd_reset_clears", 32'(all_outs()), 32'd0);
    run_move(3'd1, 2'd0, 0, lat, ocu_low);
    chk("wd_after_latency", 32'(lat), 32'd20);
`else
    chk("erro_tied_low", 32'(erro_seen), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
